aap_fetch_unit: RTL and testbench
=================================

AAP_FETCH_UNIT -- requirements
Module: aap_fetch_unit

Interface
REQ-001 Parameter PC_W, default 24, SHALL set the width of the word (16-bit) program counter.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 redirect_valid  in  1  SHALL request a PC change (branch/jump) this cycle.
REQ-006 redirect_pc  in  PC_W  SHALL be the new word PC, sampled when redirect_valid=1.
REQ-007 imem_req  out  1  SHALL be the instruction memory read strobe.
REQ-008 imem_addr  out  PC_W  SHALL be the halfword address read when imem_req=1.
REQ-009 imem_rdata  in  16  SHALL be read data, valid exactly one cycle after imem_req=1.
REQ-010 out_valid  out  1  SHALL flag a complete instruction on out_instr to the decoder.
REQ-011 out_ready  in  1  SHALL be decoder acceptance; transfer occurs when out_valid&out_ready.
REQ-012 out_instr  out  32  SHALL be the instruction: {16'h0000, lo} for 16-bit, {hi, lo} for 32-bit.
REQ-013 out_is32  out  1  SHALL be 1 when out_instr holds a 32-bit instruction.
REQ-014 out_pc  out  PC_W  SHALL be the word address of the instruction's first halfword.

Function
REQ-015 The block SHALL implement states IDLE, REQ, LO, HI, OUT.
REQ-016 IDLE: imem_req=0; next state REQ unconditionally.
REQ-017 REQ: imem_req=1, imem_addr=pc; next state LO.
REQ-018 LO, imem_rdata[15]=0: capture lo, load out_instr={16'h0,lo}, out_is32=0, out_pc=pc, pc<=pc+1, next OUT.
REQ-019 LO, imem_rdata[15]=1: capture lo, imem_req=1, imem_addr=pc+1, next HI.
REQ-020 HI: load out_instr={imem_rdata,lo}, out_is32=1, out_pc=pc, pc<=pc+2, next OUT.
REQ-021 OUT: out_valid=1; out_instr/out_is32/out_pc SHALL hold stable while out_ready=0.
REQ-022 OUT with out_ready=1: imem_req=1, imem_addr=pc in the same cycle, next LO, out_valid=0 next cycle.
REQ-023 imem_req/imem_addr SHALL be combinational from state, pc, out_ready, imem_rdata[15]; all other outputs registered.
REQ-024 out_valid SHALL be 1 only in state OUT.
REQ-025 PC arithmetic SHALL be modulo 2^PC_W; a 32-bit instruction at all-ones SHALL fetch its high half from address 0.
REQ-026 redirect_valid=1 in any state SHALL win over all other transitions: pc<=redirect_pc, out_valid<=0, next REQ, the LO/HI data returning in that cycle discarded, no imem_req beyond that of the current state.
REQ-027 Redirect coincident with out_valid&out_ready SHALL count the transfer as completed; pc still takes redirect_pc.
REQ-028 Latency: 16-bit instruction out_valid 3 edges after entering IDLE/REQ-1; 32-bit 4 edges; sustained throughput 1 per 2 cycles (16-bit) or 1 per 3 cycles (32-bit) with out_ready=1.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_is32=0, out_pc=0.
REQ-030 During reset imem_req SHALL be 0 and imem_addr SHALL be 0.
REQ-031 Reset asserted mid-instruction (LO/HI/OUT) SHALL discard the partial instruction; nothing is presented after release until a fresh fetch from RESET_PC.

Verification
REQ-032 Reset release, mem[0]=16'h6ABB, out_ready=1 -> imem_req at edge 1 addr 0; out_valid at edge 3, out_instr=32'h00006ABB, out_is32=0, out_pc=0.
REQ-033 mem[4]=16'hEA60, mem[5]=16'h5CAF, pc=4 -> second request addr 5; out_instr=32'h5CAFEA60, out_is32=1, out_pc=4, next pc=6.
REQ-034 out_ready=0 for 5 cycles in OUT -> out_valid and out_instr stable, imem_req=0 throughout; ready=1 -> next request addr=pc same cycle.
REQ-035 redirect_valid=1, redirect_pc=0x000100 while in HI -> no output for discarded instruction; next out_pc=0x000100.
REQ-036 PC_W=24, pc=0xFFFFFF, mem[0xFFFFFF]=16'h8001, mem[0]=16'h1234 -> out_instr=32'h12348001, out_is32=1, next pc=0x000001.
REQ-037 rst_n=0 asserted during HI -> out_valid=0 immediately; after release first out_pc=RESET_PC.

Source files
------------

// File: rtl/aap_fetch_unit.sv
// aap_fetch_unit: fetches 16-bit and 32-bit instructions from halfword memory.
// Bit 15 of the first halfword marks a 32-bit instruction, and the following
// halfword supplies its upper half. A redirect overrides any fetch in flight.
module aap_fetch_unit #(
   parameter int              PC_W     = 24,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic            out_is32,
   output logic [PC_W-1:0] out_pc
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_LO, S_HI, S_OUT} state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       lo_q, lo_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic              out_is32_q, out_is32_d;
   logic [PC_W-1:0]   out_pc_q, out_pc_d;

   // State register; reset returns to IDLE so a new fetch starts from RESET_PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a redirect takes priority over every other transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   state_d = S_LO;
         S_LO:    state_d = imem_rdata[15] ? S_HI : S_OUT;
         S_HI:    state_d = S_OUT;
         S_OUT:   if (out_ready) state_d = S_LO;
         default: state_d = S_IDLE;
      endcase
      if (redirect_valid) state_d = S_REQ;
   end

   // Memory request strobe and address, combinational so each read issues
   // in the same cycle as the decision to make it
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = '0;
      case (state_q)
         S_REQ: begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
         end
         S_LO: if (imem_rdata[15]) begin
            imem_req  = 1'b1;
            imem_addr = pc_q + PC_W'(1);
         end
         S_OUT: if (out_ready) begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
         end
         default: ;
      endcase
   end

   // Datapath updates: assemble the instruction, advance the PC and track the output handshake
   always_comb begin
      pc_d        = pc_q;
      lo_d        = lo_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_is32_d  = out_is32_q;
      out_pc_d    = out_pc_q;
      if (redirect_valid) begin
         // Any halfword returning this cycle belongs to the abandoned path
         pc_d        = redirect_pc;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_LO: begin
               if (imem_rdata[15]) begin
                  lo_d = imem_rdata;
               end else begin
                  out_instr_d = {16'h0000, imem_rdata};
                  out_is32_d  = 1'b0;
                  out_pc_d    = pc_q;
                  pc_d        = pc_q + PC_W'(1);
                  out_valid_d = 1'b1;
               end
            end
            S_HI: begin
               out_instr_d = {imem_rdata, lo_q};
               out_is32_d  = 1'b1;
               out_pc_d    = pc_q;
               pc_d        = pc_q + PC_W'(2);
               out_valid_d = 1'b1;
            end
            S_OUT: if (out_ready) out_valid_d = 1'b0;
            default: ;
         endcase
      end
   end

   // Datapath registers; reset discards any partially assembled instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_is32_q  <= 1'b0;
         out_pc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         lo_q        <= lo_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_is32_q  <= out_is32_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_is32  = out_is32_q;
   assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_aap_fetch_unit.sv
// Directed testbench for aap_fetch_unit with a one-cycle-latency halfword memory model.
module tb_aap_fetch_unit;

   localparam int PC_W = 24;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            redirect_valid = 1'b0;
   logic [PC_W-1:0] redirect_pc = '0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata = 16'h0000;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [31:0]     out_instr;
   logic            out_is32;
   logic [PC_W-1:0] out_pc;

   int checks = 0;
   int failures = 0;

   logic [15:0] mem [int unsigned];

   aap_fetch_unit #(.PC_W(PC_W), .RESET_PC(24'h000000)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_is32(out_is32), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_rd(input logic [PC_W-1:0] a);
      int unsigned k;
      k = int'(a);
      return mem.exists(k) ? mem[k] : 16'h0000;
   endfunction

   // Memory answers one cycle after each request
   always @(posedge clk) if (imem_req) imem_rdata <= mem_rd(imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(); step();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req got=%0b exp=0", imem_req); end
      checks++; if (imem_addr !== 24'h0) begin failures++; $display("FAIL rst_imem_addr got=%h exp=000000", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr got=%h exp=00000000", out_instr); end
      checks++; if (out_is32 !== 1'b0 || out_pc !== 24'h0) begin failures++; $display("FAIL rst_is32_pc got=%0b/%h exp=0/000000", out_is32, out_pc); end
   endtask

   task automatic test_first16();
      out_ready = 1'b1;
      rst_n = 1'b1;
      step(); // edge 1: REQ
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h0) begin failures++; $display("FAIL first_req got=%0b/%h exp=1/000000", imem_req, imem_addr); end
      step(); // edge 2: LO
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL first_early_valid got=%0b exp=0", out_valid); end
      step(); // edge 3: OUT
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0b exp=1", out_valid); end
      checks++; if (out_instr !== 32'h00006ABB) begin failures++; $display("FAIL first_instr got=%h exp=00006abb", out_instr); end
      checks++; if (out_is32 !== 1'b0 || out_pc !== 24'h0) begin failures++; $display("FAIL first_is32_pc got=%0b/%h exp=0/000000", out_is32, out_pc); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h1) begin failures++; $display("FAIL first_next_req got=%0b/%h exp=1/000001", imem_req, imem_addr); end
   endtask

   task automatic test_32bit();
      redirect_pc = 24'h000004;
      redirect_valid = 1'b1;
      step();
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h4) begin failures++; $display("FAIL b32_req_lo got=%0b/%h exp=1/000004", imem_req, imem_addr); end
      step(); // LO with EA60
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h5) begin failures++; $display("FAIL b32_req_hi got=%0b/%h exp=1/000005", imem_req, imem_addr); end
      step(); // HI
      checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL b32_hi_state got=%0b/%0b exp=0/0", out_valid, imem_req); end
      step(); // OUT
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h5CAFEA60) begin failures++; $display("FAIL b32_instr got=%0b/%h exp=1/5cafea60", out_valid, out_instr); end
      checks++; if (out_is32 !== 1'b1 || out_pc !== 24'h4) begin failures++; $display("FAIL b32_is32_pc got=%0b/%h exp=1/000004", out_is32, out_pc); end
      checks++; if (imem_addr !== 24'h6) begin failures++; $display("FAIL b32_next_pc got=%h exp=000006", imem_addr); end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1 || out_instr !== 32'h5CAFEA60 || imem_req !== 1'b0) begin
            failures++; $display("FAIL stall_hold[%0d] got=%0b/%h/%0b exp=1/5cafea60/0", i, out_valid, out_instr, imem_req); end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h6) begin failures++; $display("FAIL stall_release got=%0b/%h exp=1/000006", imem_req, imem_addr); end
      step(); // LO
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drop_valid got=%0b exp=0", out_valid); end
      step(); // OUT
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00000123 || out_pc !== 24'h6) begin
         failures++; $display("FAIL b2b_16 got=%0b/%h/%h exp=1/00000123/000006", out_valid, out_instr, out_pc); end
   endtask

   task automatic test_redirect_hi();
      step(); // LO with 9000
      checks++; if (imem_addr !== 24'h8) begin failures++; $display("FAIL redir_hi_req got=%h exp=000008", imem_addr); end
      step(); // HI
      redirect_pc = 24'h000100;
      redirect_valid = 1'b1;
      step(); // REQ
      redirect_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_discard got=%0b exp=0", out_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h100) begin failures++; $display("FAIL redir_req got=%0b/%h exp=1/000100", imem_req, imem_addr); end
      step(); // LO
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_lo_valid got=%0b exp=0", out_valid); end
      step(); // OUT
      checks++; if (out_valid !== 1'b1 || out_pc !== 24'h100 || out_instr !== 32'h00002222) begin
         failures++; $display("FAIL redir_out got=%0b/%h/%h exp=1/000100/00002222", out_valid, out_pc, out_instr); end
   endtask

   task automatic test_wrap();
      // Redirect coincident with an accepted transfer
      redirect_pc = 24'hFFFFFF;
      redirect_valid = 1'b1;
      step();
      redirect_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || imem_addr !== 24'hFFFFFF) begin failures++; $display("FAIL wrap_req got=%0b/%h exp=0/ffffff", out_valid, imem_addr); end
      step(); // LO with 8001
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h0) begin failures++; $display("FAIL wrap_hi_addr got=%0b/%h exp=1/000000", imem_req, imem_addr); end
      step(); step(); // HI, OUT
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h12348001 || out_is32 !== 1'b1) begin
         failures++; $display("FAIL wrap_instr got=%0b/%h/%0b exp=1/12348001/1", out_valid, out_instr, out_is32); end
      checks++; if (out_pc !== 24'hFFFFFF || imem_addr !== 24'h1) begin failures++; $display("FAIL wrap_pc got=%h/%h exp=ffffff/000001", out_pc, imem_addr); end
   endtask

   task automatic test_reset_mid();
      step(); // LO with C000
      step(); // HI
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_pc !== 24'h0 || out_instr !== 32'h0) begin
         failures++; $display("FAIL midrst_clear got=%0b/%h/%h exp=0/000000/00000000", out_valid, out_pc, out_instr); end
      checks++; if (imem_req !== 1'b0 || imem_addr !== 24'h0) begin failures++; $display("FAIL midrst_imem got=%0b/%h exp=0/000000", imem_req, imem_addr); end
      step(); step();
      rst_n = 1'b1;
      step(); // REQ
      checks++; if (imem_req !== 1'b1 || imem_addr !== 24'h0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL midrst_refetch got=%0b/%h/%0b exp=1/000000/0", imem_req, imem_addr, out_valid); end
      step(); // LO
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%0b exp=0", out_valid); end
      step(); // OUT
      checks++; if (out_valid !== 1'b1 || out_pc !== 24'h0 || out_instr !== 32'h00006ABB) begin
         failures++; $display("FAIL midrst_first got=%0b/%h/%h exp=1/000000/00006abb", out_valid, out_pc, out_instr); end
   endtask

   task automatic test_back_to_back();
      // Accepted at OUT; next is 32-bit C000 at pc 1, so 3 cycles to the next output
      step(); // LO
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_lo got=%0b exp=0", out_valid); end
      step(); // HI
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_hi got=%0b exp=0", out_valid); end
      step(); // OUT
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0000C000 || out_is32 !== 1'b1 || out_pc !== 24'h1) begin
         failures++; $display("FAIL b2b_32 got=%0b/%h/%0b/%h exp=1/0000c000/1/000001", out_valid, out_instr, out_is32, out_pc); end
   endtask

   initial begin
      mem[0]        = 16'h6ABB;
      mem[1]        = 16'hC000;
      mem[4]        = 16'hEA60;
      mem[5]        = 16'h5CAF;
      mem[6]        = 16'h0123;
      mem[7]        = 16'h9000;
      mem[8]        = 16'h1111;
      mem[32'h100]  = 16'h2222;
      mem[32'hFFFFFF] = 16'h8001;
      mem[0] = 16'h6ABB;
      // mem[0] also serves as the high half of the wrapped 32-bit instruction
      test_reset();
      test_first16();
      test_32bit();
      test_stall();
      test_redirect_hi();
      mem[0] = 16'h1234;
      test_wrap();
      mem[0] = 16'h6ABB;
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
